// File: rtl/ntt_stream_seq.sv
// ntt_stream_seq: command sequencer streaming source memory into an NTT core, plus result capture.
// Define NTT_SEQ_CAPTURE_EN to build the reduced, de-interleaved capture path.
`timescale 1ns/1ps
`default_nettype none

module ntt_stream_seq #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 12,
  parameter int unsigned LW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic [LW-1:0] cmd_len,
  input  logic [AW-1:0] cmd_base,
  input  logic [LW-1:0] cmd_wait,
  input  logic          cmd_drain,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [4:0]    op_code,
  output logic          din_valid,
  output logic [DW-1:0] din0,
  input  logic [DW-1:0] dout0,
  input  logic          core_done,
  input  logic [DW-1:0] q,
  input  logic [LW-1:0] cap_n,
  output logic          cap_valid,
  output logic [LW-1:0] cap_idx,
  output logic [DW-1:0] cap_data,
  output logic          cap_busy,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPC    = 3'd1,
    S_STREAM = 3'd2,
    S_TAIL   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    op_q;
  logic [LW-1:0] len_q, wait_q, cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          drain_q;
  logic          w_accept;

  assign w_accept = cmd_valid & cmd_ready;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      len_q   <= '0;
      wait_q  <= '0;
      drain_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        op_q    <= cmd_op;
        len_q   <= cmd_len;
        wait_q  <= cmd_wait;
        drain_q <= cmd_drain;
        addr_q  <= cmd_base;
      end else begin
        addr_q  <= addr_d;
      end
    end
  end

  // addr_q tracks the word being presented; the read for the next word is issued one cycle ahead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cmd_ready = 1'b0;
    op_code   = '0;
    din_valid = 1'b0;
    din0      = '0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_OPC;
      end
      S_OPC: begin
        op_code   = op_q;
        din_valid = drain_q;
        cnt_d     = '0;
        if ((len_q != '0) && !drain_q) begin
          mem_re   = 1'b1;
          mem_addr = addr_q;
        end
        state_d = (len_q != '0) ? S_STREAM : S_TAIL;
      end
      S_STREAM: begin
        din_valid = 1'b1;
        din0      = drain_q ? '0 : mem_rdata;
        addr_d    = addr_q + AW'(1);
        cnt_d     = cnt_q + LW'(1);
        if (!drain_q && (cnt_q != len_q - LW'(1))) begin
          mem_re   = 1'b1;
          mem_addr = addr_q + AW'(1);
        end
        if (cnt_q == len_q - LW'(1)) state_d = S_TAIL;
      end
      S_TAIL: begin
        cnt_d   = '0;
        state_d = (wait_q != '0) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        cnt_d = cnt_q + LW'(1);
        if (cnt_q == wait_q - LW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef NTT_SEQ_CAPTURE_EN
  logic          done_q, armed_q, cap_act_q;
  logic [LW-1:0] cap_m_q, cap_n_q;
  logic          w_rise;

  // armed_q masks the first cycle after reset so a level held through release is not an edge.
  assign w_rise = core_done & ~done_q & armed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      cap_act_q <= 1'b0;
      cap_m_q   <= '0;
      cap_n_q   <= '0;
    end else begin
      done_q  <= core_done;
      armed_q <= 1'b1;
      if (cap_act_q) begin
        cap_m_q <= cap_m_q + LW'(1);
        if (cap_m_q == cap_n_q - LW'(1)) cap_act_q <= 1'b0;
      end else if (w_rise && (cap_n != '0)) begin
        cap_act_q <= 1'b1;
        cap_m_q   <= '0;
        cap_n_q   <= cap_n;
      end
    end
  end

  always_comb begin
    cap_valid = cap_act_q;
    cap_busy  = cap_act_q;
    cap_idx   = '0;
    cap_data  = '0;
    if (cap_act_q) begin
      cap_idx  = cap_m_q[0] ? ((cap_m_q >> 1) + (cap_n_q >> 1)) : (cap_m_q >> 1);
      cap_data = (dout0 >= q) ? (dout0 - q) : dout0;
    end
  end
`else
  logic unused_cap;

  assign unused_cap = ^{q, cap_n, dout0, core_done};
  assign cap_valid  = 1'b0;
  assign cap_busy   = 1'b0;
  assign cap_idx    = '0;
  assign cap_data   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntt_stream_seq.sv
// Scoreboard bench for ntt_stream_seq: driver pushes expected beats, negedge monitor pops and compares.
`timescale 1ns/1ps
`default_nettype none

module tb_ntt_stream_seq;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [4:0]    cmd_op = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_wait = '0;
  logic          cmd_drain = 1'b0;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [4:0]    op_code;
  logic          din_valid;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;
  logic          core_done = 1'b0;
  logic [DW-1:0] q = '0;
  logic [LW-1:0] cap_n = '0;
  logic          cap_valid;
  logic [LW-1:0] cap_idx;
  logic [DW-1:0] cap_data;
  logic          cap_busy;
  logic          busy;

  ntt_stream_seq #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_base(cmd_base), .cmd_wait(cmd_wait), .cmd_drain(cmd_drain),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .op_code(op_code), .din_valid(din_valid), .din0(din0),
    .dout0(dout0), .core_done(core_done), .q(q), .cap_n(cap_n),
    .cap_valid(cap_valid), .cap_idx(cap_idx), .cap_data(cap_data), .cap_busy(cap_busy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  logic [4:0]    exp_op   [$];
  logic [DW-1:0] exp_din  [$];
  logic [AW-1:0] exp_addr [$];
  logic [LW-1:0] exp_idx  [$];
  logic [DW-1:0] exp_cap  [$];
  logic [DW-1:0] cap_vals [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d expected=no output", name, act);
  endtask

  // Monitor: every presented output beat must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (op_code != 5'd0) begin
        if (exp_op.size() == 0) fail_unexpected("op_code", op_code);
        else chk("op_code", op_code, exp_op.pop_front());
      end
      if (din_valid) begin
        if (exp_din.size() == 0) fail_unexpected("din0", din0);
        else chk("din0", din0, exp_din.pop_front());
      end else if (din0 != '0) begin
        fail_unexpected("din0_idle", din0);
      end
      if (mem_re) begin
        if (exp_addr.size() == 0) fail_unexpected("mem_addr", mem_addr);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (cap_valid) begin
        if (exp_idx.size() == 0) fail_unexpected("cap_idx", cap_idx);
        else begin
          chk("cap_idx", cap_idx, exp_idx.pop_front());
          chk("cap_data", cap_data, exp_cap.pop_front());
        end
      end
      if (cap_busy !== cap_valid) chk("cap_busy", cap_busy, cap_valid);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_code"}, op_code, 0);
    chk({tag, "_din_valid"}, din_valid, 0);
    chk({tag, "_din0"}, din0, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_cap_valid"}, cap_valid, 0);
    chk({tag, "_cap_idx"}, cap_idx, 0);
    chk({tag, "_cap_data"}, cap_data, 0);
    chk({tag, "_cap_busy"}, cap_busy, 0);
  endtask

  // Waits for IDLE, presents the command, pushes the expected stream, returns just after acceptance.
  task automatic start_cmd(input logic [4:0] op, input int len, input int base, input int wt, input bit drain);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LW'(len);
    cmd_base  = AW'(base);
    cmd_wait  = LW'(wt);
    cmd_drain = drain;
    exp_op.push_back(op);
    if (drain) begin
      for (int i = 0; i <= len; i++) exp_din.push_back('0);
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_din.push_back(mem[(base + i) % 4096]);
        exp_addr.push_back(AW'((base + i) % 4096));
      end
    end
    @(posedge clk);
  endtask

  // Full command: a rejected cmd_valid in the OPC cycle, then the ready-return latency check.
  task automatic issue(input logic [4:0] op, input int len, input int base, input int wt, input bit drain);
    int k;
    start_cmd(op, len, base, wt, drain);
    #1;
    cmd_op   = op ^ 5'h15;
    cmd_base = cmd_base + AW'(7);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 1;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 5000);
    chk("ready_latency", k, 3 + len + wt);
  endtask

  task automatic capture(input int n, input logic [DW-1:0] qv);
    @(posedge clk); #1;
    q     = qv;
    cap_n = LW'(n);
    for (int m = 0; m < n; m++) begin
      exp_idx.push_back(LW'((m % 2 == 0) ? m / 2 : m / 2 + n / 2));
      exp_cap.push_back((cap_vals[m] >= qv) ? cap_vals[m] - qv : cap_vals[m]);
    end
    core_done = 1'b1;
    for (int m = 0; m < n; m++) begin
      @(posedge clk); #1;
      dout0 = cap_vals[m];
      if (m == 1) core_done = 1'b0;
      if (m == 3) core_done = 1'b1;
    end
    @(posedge clk); #1;
    dout0     = '0;
    core_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic random_capture(input int n);
    logic [DW-1:0] qv;
    qv = DW'($urandom_range(3, 32'h7fff_ffff));
    cap_vals.delete();
    for (int m = 0; m < n; m++)
      cap_vals.push_back(($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2 * qv - 1)));
    capture(n, qv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    #3;
    check_reset_outputs("reset");
    #9 reset = 1'b1;

    mem[0] = 32'd2;
    mem[1] = 32'd7342081;
    mem[2] = 32'd4188161;
    issue(5'b00001, 3, 0, 0, 0);
    issue(5'b00100, 0, $urandom_range(0, 4095), 156, 0);
    issue(5'b01011, 42, $urandom_range(0, 4095), 0, 1);
    issue(5'd9, 4, 4094, 0, 0);
    issue(5'd3, 0, 0, 0, 1);

    for (int t = 0; t < 25; t++)
      issue(5'($urandom_range(1, 31)), $urandom_range(0, 20), $urandom_range(0, 4095),
            $urandom_range(0, 10), ($urandom_range(0, 3) == 0));

`ifdef NTT_SEQ_CAPTURE_EN
    cap_vals.delete();
    for (int m = 0; m < 6; m++) cap_vals.push_back(DW'(m));
    cap_vals.push_back(32'd7342081);
    cap_vals.push_back(32'd7342082);
    capture(8, 32'd7342081);
    random_capture(0);
    random_capture(1);
    random_capture(7);
    fork
      random_capture(24);
      issue(5'd17, 12, $urandom_range(0, 4095), 3, 0);
    join
`endif

    // Reset while streaming word 10 of a 128-word command.
    start_cmd(5'd6, 128, $urandom_range(0, 4095), 5, 0);
    #1 cmd_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_op.delete();
    exp_din.delete();
    exp_addr.delete();
`ifdef NTT_SEQ_CAPTURE_EN
    core_done = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 core_done = 1'b0;
    issue(5'd21, 9, $urandom_range(0, 4095), 2, 0);

    repeat (5) @(posedge clk);
    chk("op_queue_left", exp_op.size(), 0);
    chk("din_queue_left", exp_din.size(), 0);
    chk("addr_queue_left", exp_addr.size(), 0);
    chk("cap_queue_left", exp_idx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
